// File: rtl/enc_reverse_pkg.sv
// Shared types for the reverse stream engine: FSM state encoding
// and word transform mode codes.
package enc_reverse_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_ELEM = 2'd1;
    localparam logic [1:0] MODE_BITS = 2'd2;

endpackage

// File: rtl/reverse_serializer.sv
// Word buffer feeding an MSB-first beat serialiser with val/rdy output.
// Occupancy is exported so the fetch side can issue read credit.
module reverse_serializer #(
    parameter int IN_W      = 128,
    parameter int OUT_W     = 8,
    parameter int BUF_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic [IN_W-1:0]                i_push_data,
    input  logic                           i_rdy,
    output logic [$clog2(BUF_DEPTH+1)-1:0] o_occ,
    output logic                           o_val,
    output logic [OUT_W-1:0]               o_dat,
    output logic                           o_pop
);

    localparam int BPW = IN_W / OUT_W;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OW  = $clog2(BUF_DEPTH + 1);

    logic [IN_W-1:0]  r_mem [BUF_DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [OW-1:0]    r_occ;
    logic [BW-1:0]    r_beat;
    logic [IN_W-1:0]  w_head;
    logic [OUT_W-1:0] w_beats [BPW];
    logic             w_hs;
    logic             w_last;

    assign w_head = r_mem[r_rptr];
    assign o_val  = (r_occ != '0);
    assign w_hs   = o_val & i_rdy;
    assign w_last = (BPW == 1) || (r_beat == BW'(BPW - 1));
    assign o_pop  = w_hs & w_last;
    assign o_occ  = r_occ;

    for (genvar b = 0; b < BPW; b++) begin : g_beat
        assign w_beats[b] = w_head[IN_W-1-b*OUT_W -: OUT_W];
    end

    // Gated by valid so the data port reads zero whenever the buffer is empty.
    assign o_dat = o_val ? w_beats[r_beat] : '0;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
            r_beat <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= (r_wptr == PW'(BUF_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
            end
            if (o_pop) begin
                r_rptr <= (r_rptr == PW'(BUF_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
            end
            if (w_hs) begin
                r_beat <= w_last ? '0 : r_beat + BW'(1);
            end
            case ({i_push, o_pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/reverse_stream_engine.sv
// Fetches a run of words, optionally reverses elements or bits, and
// streams each word MSB-first as back-pressured beats.
module reverse_stream_engine
    import enc_reverse_pkg::*;
#(
    parameter int IN_W      = 128,
    parameter int ELEM_W    = 8,
    parameter int OUT_W     = 8,
    parameter int LEN_W     = 16,
    parameter int BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sys_start_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic [1:0]       cfg_mode_i,
    output logic             sys_busy_o,
    output logic             sys_done_o,
    output logic             start_err_o,
    output logic             rden_o,
    input  logic [IN_W-1:0]  data_i,
    output logic             bs_val_o,
    output logic [OUT_W-1:0] bs_dat_o,
    input  logic             bs_rdy_i
);

    localparam int NE = IN_W / ELEM_W;
    localparam int OW = $clog2(BUF_DEPTH + 1);

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_left;
    logic [1:0]       r_mode;
    logic             r_inflight;
    logic [OW-1:0]    w_occ;
    logic             w_pop;
    logic             w_credit;
    logic             w_rden;
    logic             w_accept;
    logic [IN_W-1:0]  w_elem;
    logic [IN_W-1:0]  w_bitr;
    logic [IN_W-1:0]  w_xf;

    assign w_accept = (r_state == S_IDLE) & sys_start_i;
    // A read in flight already owns one buffer slot.
    assign w_credit = r_inflight ? (w_occ < OW'(BUF_DEPTH - 1))
                                 : (w_occ < OW'(BUF_DEPTH));
    assign w_rden   = (r_state == S_FETCH) && (r_left != '0) && w_credit;

    assign rden_o      = w_rden;
    assign sys_busy_o  = (r_state != S_IDLE);
    assign sys_done_o  = (r_state == S_DONE);
    assign start_err_o = sys_start_i & (r_state != S_IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (sys_start_i) begin
                    w_next = (cfg_len_i == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_rden && (r_left == LEN_W'(1))) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && (w_occ == OW'(1)) && !r_inflight) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_left     <= '0;
            r_mode     <= MODE_PASS;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_rden;
            if (w_accept) begin
                r_left <= cfg_len_i;
                r_mode <= cfg_mode_i;
            end else if (w_rden) begin
                r_left <= r_left - LEN_W'(1);
            end
        end
    end

    for (genvar k = 0; k < NE; k++) begin : g_elem
        assign w_elem[k*ELEM_W +: ELEM_W] = data_i[(NE-1-k)*ELEM_W +: ELEM_W];
    end

    for (genvar i = 0; i < IN_W; i++) begin : g_bit
        assign w_bitr[i] = data_i[IN_W-1-i];
    end

    always_comb begin
        w_xf = data_i;
        case (r_mode)
            MODE_ELEM: w_xf = w_elem;
            MODE_BITS: w_xf = w_bitr;
            default:   w_xf = data_i;
        endcase
    end

    reverse_serializer #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (w_xf),
        .i_rdy       (bs_rdy_i),
        .o_occ       (w_occ),
        .o_val       (bs_val_o),
        .o_dat       (bs_dat_o),
        .o_pop       (w_pop)
    );

endmodule

// File: tb/tb_reverse_stream_engine.sv
// Scoreboard bench for reverse_stream_engine: expected beats are queued
// when each read word is supplied and popped as beats handshake.
module tb_reverse_stream_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sys_start_i = 1'b0;
    logic [15:0]  cfg_len_i = '0;
    logic [1:0]   cfg_mode_i = '0;
    logic         sys_busy_o;
    logic         sys_done_o;
    logic         start_err_o;
    logic         rden_o;
    logic [127:0] data_i = '0;
    logic         bs_val_o;
    logic [7:0]   bs_dat_o;
    logic         bs_rdy_i = 1'b1;

    always #5 clk = ~clk;

    reverse_stream_engine dut (
        .clk         (clk),
        .rst         (rst),
        .sys_start_i (sys_start_i),
        .cfg_len_i   (cfg_len_i),
        .cfg_mode_i  (cfg_mode_i),
        .sys_busy_o  (sys_busy_o),
        .sys_done_o  (sys_done_o),
        .start_err_o (start_err_o),
        .rden_o      (rden_o),
        .data_i      (data_i),
        .bs_val_o    (bs_val_o),
        .bs_dat_o    (bs_dat_o),
        .bs_rdy_i    (bs_rdy_i)
    );

    int n_vec = 0;
    int n_mis = 0;

    logic [7:0]   exp_q[$];
    logic [7:0]   log_q[$];
    logic [127:0] mem [8];
    logic [127:0] drv_w;
    logic [1:0]   mdl_mode = '0;
    logic [7:0]   prev_dat = '0;
    bit           rd_seen = 0;
    bit           rand_rdy = 0;
    bit           prev_stall = 0;
    int widx = 0, n_rden = 0, n_done = 0, n_serr = 0, n_busy = 0;
    int n_val = 0, n_beats = 0, issued = 0, completed = 0, bidx = 0;
    int cyc = 0, done_cyc = 0, hs_cyc = 0, start_cyc = 0;
    int first_val_cyc = 0, first_rd_cyc = 0;

    localparam logic [127:0] PAT = 128'h000102030405060708090A0B0C0D0E0F;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] xform(input logic [127:0] w,
                                           input logic [1:0] m);
        logic [127:0] r;
        r = w;
        if (m == 2'd1) begin
            for (int k = 0; k < 16; k++) r[k*8 +: 8] = w[(15-k)*8 +: 8];
        end else if (m == 2'd2) begin
            for (int i = 0; i < 128; i++) r[i] = w[127-i];
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Observation point: mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
            rd_seen    = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_val", bs_val_o, 1);
                chk("hold_dat", bs_dat_o, prev_dat);
            end
            prev_stall = bs_val_o && !bs_rdy_i;
            prev_dat   = bs_dat_o;
            if (rden_o) begin
                chk("credit", (issued - completed) < 2, 1);
                if (n_rden == 0) first_rd_cyc = cyc;
                issued++;
                n_rden++;
            end
            rd_seen = rden_o;
            if (sys_done_o) begin
                n_done++;
                done_cyc = cyc;
            end
            if (start_err_o) n_serr++;
            if (sys_busy_o) n_busy++;
            if (bs_val_o) begin
                if (n_val == 0) first_val_cyc = cyc;
                n_val++;
            end
            if (sys_start_i && !sys_busy_o) start_cyc = cyc;
            if (bs_val_o && bs_rdy_i) begin
                log_q.push_back(bs_dat_o);
                n_beats++;
                hs_cyc = cyc;
                if (exp_q.size() == 0) chk("beat_extra", exp_q.size(), 1);
                else chk("beat", bs_dat_o, exp_q.pop_front());
                if (bidx == 15) begin
                    bidx = 0;
                    completed++;
                end else begin
                    bidx++;
                end
            end
        end
    end

    // Read-port model: data valid the cycle after rden_o, garbage otherwise.
    always @(posedge clk) begin
        #1;
        bs_rdy_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rd_seen && !rst && widx < 8) begin
            data_i = mem[widx];
            drv_w  = xform(mem[widx], mdl_mode);
            for (int b = 0; b < 16; b++) exp_q.push_back(drv_w[127-8*b -: 8]);
            widx++;
        end else begin
            data_i = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    task automatic launch(input int len, input logic [1:0] mode);
        @(posedge clk);
        #2;
        exp_q.delete();
        log_q.delete();
        widx = 0; n_rden = 0; n_beats = 0; n_busy = 0; n_val = 0;
        n_done = 0; n_serr = 0; issued = 0; completed = 0; bidx = 0;
        mdl_mode    = mode;
        sys_start_i = 1'b1;
        cfg_len_i   = 16'(len);
        cfg_mode_i  = mode;
        @(posedge clk);
        #2;
        sys_start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int len);
        int t;
        t = 0;
        while (n_done == 0 && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk({tag, "_timeout"}, n_done != 0, 1);
        repeat (4) @(negedge clk);
        #1;
        chk({tag, "_done_cnt"}, n_done, 1);
        chk({tag, "_rden_cnt"}, n_rden, len);
        chk({tag, "_beat_cnt"}, n_beats, len * 16);
        chk({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rden"}, rden_o, 0);
        chk({tag, "_busy"}, sys_busy_o, 0);
        chk({tag, "_done"}, sys_done_o, 0);
        chk({tag, "_err"}, start_err_o, 0);
        chk({tag, "_val"}, bs_val_o, 0);
        chk({tag, "_dat"}, bs_dat_o, 0);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk_idle("rst");
        @(posedge clk);
        #2;
        rst = 1'b0;

        mem[0] = PAT;
        launch(1, 2'd0);
        wait_done("t1", 1);
        chk("t1_b0", log_q[0], 8'h00);
        chk("t1_b15", log_q[15], 8'h0F);
        chk("t1_rd_lat", first_rd_cyc, start_cyc + 1);
        chk("t1_val_lat", first_val_cyc, start_cyc + 3);
        chk("t1_done_lat", done_cyc, hs_cyc + 1);

        launch(1, 2'd1);
        wait_done("t2e", 1);
        chk("t2e_b0", log_q[0], 8'h0F);
        chk("t2e_b15", log_q[15], 8'h00);

        mem[0] = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
        launch(1, 2'd2);
        wait_done("t2b", 1);
        chk("t2b_b0", log_q[0], 8'h00);
        chk("t2b_b15", log_q[15], 8'h01);

        for (int i = 0; i < 4; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        rand_rdy = 1;
        launch(4, 2'd1);
        wait_done("t3", 4);
        rand_rdy = 0;

        launch(0, 2'd0);
        wait_done("t4", 0);
        chk("t4_val", n_val, 0);
        chk("t4_busy", n_busy, 1);
        chk("t4_done_at", done_cyc, start_cyc + 1);

        for (int i = 0; i < 2; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        launch(2, 2'd0);
        repeat (5) @(posedge clk);
        #2;
        sys_start_i = 1'b1;
        cfg_len_i   = 16'd9;
        cfg_mode_i  = 2'd2;
        @(posedge clk);
        #2;
        sys_start_i = 1'b0;
        wait_done("t5", 2);
        chk("t5_err_cnt", n_serr, 1);

        for (int i = 0; i < 3; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        launch(3, 2'd0);
        t = 0;
        while (n_beats < 40 && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("t6_reach", n_beats, 40);
        rst = 1'b1;
        #1;
        chk_idle("t6_rst");
        repeat (5) @(negedge clk);
        chk("t6_no_done", n_done, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        mem[0] = PAT;
        launch(1, 2'd0);
        wait_done("t6r", 1);
        chk("t6r_b0", log_q[0], 8'h00);
        chk("t6r_b15", log_q[15], 8'h0F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
